// File: rtl/data_block_memory.sv
// Main data memory behind the L1 data cache: whole-block refills and write-backs
// with a fixed access latency. Optional completion counters under `DMEM_STATS_EN.
module data_block_memory #(
  parameter int DEPTH_BLOCKS = 256,
  parameter int LATENCY      = 4,
  localparam int AW          = $clog2(DEPTH_BLOCKS)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [27:0]  ADDRESS,
  input  logic [127:0] WRITE_DATA,
  output logic [127:0] READ_DATA,
  output logic         BUSY_WAIT,
  output logic [31:0]  READ_COUNT,
  output logic [31:0]  WRITE_COUNT
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   counter;
  logic            op_write;
  logic [AW-1:0]   op_index;
  logic [127:0]    op_data;
  logic            request;
  logic            accept;
  logic            access_now;
  logic            unused_addr_bits;

  logic [127:0] mem [DEPTH_BLOCKS];

  assign request    = READ | WRITE;
  assign accept     = (state == IDLE) && request;
  assign access_now = (state == ACCESS) && (counter == '0);

  // Upper address bits alias onto the same blocks by design.
  assign unused_addr_bits = ^ADDRESS[27:AW];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (request) state_next = ACCESS;
      ACCESS:  if (counter == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY_WAIT = 1'b0;
    if (!RESET) begin
      unique case (state)
        IDLE:    BUSY_WAIT = request;
        ACCESS:  BUSY_WAIT = 1'b1;
        DONE:    BUSY_WAIT = 1'b0;
        default: BUSY_WAIT = 1'b0;
      endcase
    end
  end

  // Request is captured at acceptance so later input changes cannot disturb it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      counter   <= '0;
      op_write  <= 1'b0;
      op_index  <= '0;
      op_data   <= '0;
      READ_DATA <= '0;
    end else begin
      if (accept) begin
        op_write <= WRITE;
        op_index <= ADDRESS[AW-1:0];
        op_data  <= WRITE_DATA;
        counter  <= CW'(LATENCY - 1);
      end else if (state == ACCESS && counter != '0) begin
        counter <= counter - CW'(1);
      end
      if (access_now && !op_write) READ_DATA <= mem[op_index];
    end
  end

  // NOTE: the storage array has no reset; it keeps contents across RESET and
  // maps onto plain RAM. An abort is safe because RESET forces state to IDLE.
  always_ff @(posedge CLK) begin
    if (access_now && op_write) mem[op_index] <= op_data;
  end

`ifdef DMEM_STATS_EN
  logic [31:0] read_count_q, write_count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else if (access_now) begin
      if (op_write) begin
        if (write_count_q != 32'hFFFF_FFFF) write_count_q <= write_count_q + 32'd1;
      end else begin
        if (read_count_q != 32'hFFFF_FFFF) read_count_q <= read_count_q + 32'd1;
      end
    end
  end

  assign READ_COUNT  = read_count_q;
  assign WRITE_COUNT = write_count_q;
`else
  assign READ_COUNT  = '0;
  assign WRITE_COUNT = '0;
`endif

endmodule

// File: tb/tb_data_block_memory.sv
// Randomized self-checking bench for data_block_memory against an array-based
// model of block storage, per-request busy window and completion counts.
module tb_data_block_memory;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;
  localparam int AW    = $clog2(DEPTH);

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ, WRITE;
  logic [27:0]  ADDRESS;
  logic [127:0] WRITE_DATA;
  logic [127:0] READ_DATA;
  logic         BUSY_WAIT;
  logic [31:0]  READ_COUNT, WRITE_COUNT;

  data_block_memory #(.DEPTH_BLOCKS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
    .BUSY_WAIT(BUSY_WAIT), .READ_COUNT(READ_COUNT), .WRITE_COUNT(WRITE_COUNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: block contents, last read result, completion counts.
  logic [127:0] ref_mem [int];
  int           written_q [$];
  logic [127:0] exp_rd_data = '0;
  longint       n_reads  = 0;
  longint       n_writes = 0;

  function automatic logic [31:0] exp_count(input longint n);
`ifdef DMEM_STATS_EN
    return (n > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_counts(input string tag);
    total++;
    if (READ_COUNT !== exp_count(n_reads)) begin
      bad++;
      $display("FAIL %s read_count got=%0d want=%0d", tag, READ_COUNT, exp_count(n_reads));
    end
    total++;
    if (WRITE_COUNT !== exp_count(n_writes)) begin
      bad++;
      $display("FAIL %s write_count got=%0d want=%0d", tag, WRITE_COUNT, exp_count(n_writes));
    end
  endtask

  // Starts at posedge+1 in IDLE; returns at posedge+1 in the following IDLE cycle.
  task automatic do_op(input string tag, input bit is_wr, input bit both,
                       input logic [27:0] addr, input logic [127:0] wdata,
                       input logic [27:0] alt_addr, input bit hold);
    int n;
    int idx;
    idx        = int'(addr[AW-1:0]);
    READ       = !is_wr || both;
    WRITE      = is_wr;
    ADDRESS    = addr;
    WRITE_DATA = wdata;
    if (is_wr) begin
      ref_mem[idx] = wdata;
      written_q.push_back(idx);
      n_writes++;
    end else begin
      exp_rd_data = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
      n_reads++;
    end
    @(negedge CLK);
    n = 0;
    while (BUSY_WAIT === 1'b1 && n < 20) begin
      n++;
      @(posedge CLK); #1;
      if (!hold) begin
        READ       = 1'b0;
        WRITE      = 1'b0;
        ADDRESS    = alt_addr;
        WRITE_DATA = rand128();
      end
      @(negedge CLK);
    end
    total++;
    if (n != LAT + 1) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", tag, n, LAT + 1);
    end
    total++;
    if (BUSY_WAIT !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_in_done got=%b want=0", tag, BUSY_WAIT);
    end
    total++;
    if (READ_DATA !== exp_rd_data) begin
      bad++;
      $display("FAIL %s read_data got=%h want=%h", tag, READ_DATA, exp_rd_data);
    end
    check_counts(tag);
    @(posedge CLK); #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = '0; WRITE_DATA = '0;
    #1;
    total++;
    if (BUSY_WAIT !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", BUSY_WAIT);
    end
    total++;
    if (READ_DATA !== 128'd0) begin
      bad++; $display("FAIL reset_read_data got=%h want=0", READ_DATA);
    end
    check_counts("reset");
    READ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_read_latency();
    do_op("preload5", 1'b1, 1'b0, 28'h0000005, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, '0, 1'b0);
    do_op("read5", 1'b0, 1'b0, 28'h0000005, '0, 28'h0000006, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op("wb12", 1'b1, 1'b0, 28'h0000012, {4{32'hA5A5_A5A5}}, '0, 1'b0);
    do_op("refill12", 1'b0, 1'b0, 28'h0000012, '0, '0, 1'b0);
  endtask

  task automatic test_alias();
    do_op("wr103", 1'b1, 1'b0, 28'h0000103, {4{32'hDEAD_BEEF}}, '0, 1'b0);
    do_op("rd003", 1'b0, 1'b0, 28'h0000003, '0, '0, 1'b0);
  endtask

  task automatic test_drop();
    do_op("wr7", 1'b1, 1'b0, 28'h0000007, {4{32'hC3C3_3C3C}}, '0, 1'b0);
    do_op("wr9_drop", 1'b1, 1'b0, 28'h0000009, {4{32'h9999_0000}}, 28'h0000007, 1'b0);
    do_op("rd9", 1'b0, 1'b0, 28'h0000009, '0, '0, 1'b0);
    do_op("rd7", 1'b0, 1'b0, 28'h0000007, '0, '0, 1'b0);
  endtask

  task automatic test_done_ignored();
    do_op("hold_rd12", 1'b0, 1'b0, 28'h0000012, '0, '0, 1'b1);
    do_op("hold_both", 1'b1, 1'b1, 28'h0000020, rand128(), '0, 1'b1);
    do_op("rd20", 1'b0, 1'b0, 28'h0000020, '0, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [27:0] a;
      a = {20'($urandom), 8'($urandom)};
      if (written_q.size() > 0 && ($urandom % 2) == 0) begin
        a[AW-1:0] = AW'(written_q[$urandom % written_q.size()]);
        do_op("rand_rd", 1'b0, 1'b0, a, rand128(), 28'($urandom), 1'($urandom));
      end else begin
        do_op("rand_wr", 1'b1, 1'($urandom), a, rand128(), 28'($urandom), 1'b0);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_op("wr4_old", 1'b1, 1'b0, 28'h0000004, {4{32'h1111_1111}}, '0, 1'b0);
    do_op("rd4_pre", 1'b0, 1'b0, 28'h0000004, '0, '0, 1'b0);
    WRITE = 1'b1; ADDRESS = 28'h0000004; WRITE_DATA = {4{32'h2222_2222}};
    @(posedge CLK); #1;
    WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    exp_rd_data = '0;
    n_reads     = 0;
    n_writes    = 0;
    total++;
    if (BUSY_WAIT !== 1'b0) begin
      bad++; $display("FAIL abort_busy got=%b want=0", BUSY_WAIT);
    end
    total++;
    if (READ_DATA !== 128'd0) begin
      bad++; $display("FAIL abort_read_data got=%h want=0", READ_DATA);
    end
    check_counts("abort");
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    do_op("rd4_post", 1'b0, 1'b0, 28'h0000004, '0, '0, 1'b0);
    do_op("wr_post", 1'b1, 1'b0, 28'h0000030, rand128(), '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_alias();
    test_drop();
    test_done_ignored();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
